// File: rtl/acc_pkg.sv
// acc_pkg: shared constants and types for the accumulator result drain
package acc_pkg;
  localparam int LANES = 10;
  localparam int DW = 32;
  localparam int IDXW = 4;
  typedef logic signed [DW-1:0] lane_t;
  typedef lane_t vec_t [LANES-1:0];
  typedef enum logic {IDLE, SEND} drain_state_e;
endpackage

// File: rtl/acc_drain.sv
// acc_drain: serialises a captured result vector lane by lane and reports its signed argmax
module acc_drain
  import acc_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pre_valid,
  output logic            o_pre_ready,
  input  vec_t            i_res,
  output logic            o_post_valid,
  input  logic            i_post_ready,
  output logic [DW-1:0]   o_data,
  output logic [IDXW-1:0] o_idx,
  output logic            o_last,
  output logic            o_class_valid,
  output logic [IDXW-1:0] o_class
);
  drain_state_e state;
  vec_t vec;
  lane_t max_v;
  logic [IDXW-1:0] max_i, nxt, fin_i;
  logic pre_fire, post_fire, gt;
  assign o_pre_ready = (state == IDLE) | ((state == SEND) & o_last & i_post_ready);
  assign pre_fire = i_pre_valid & o_pre_ready;
  assign post_fire = o_post_valid & i_post_ready;
  assign nxt = o_idx + 1'b1;
  assign gt = $signed(o_data) > max_v;
  assign fin_i = gt ? o_idx : max_i;
  // drain FSM, running argmax and class publication; the beat registers index the captured vector
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      vec <= '{default: '0};
      max_v <= '0;
      max_i <= '0;
      o_post_valid <= 1'b0;
      o_data <= '0;
      o_idx <= '0;
      o_last <= 1'b0;
      o_class_valid <= 1'b0;
      o_class <= '0;
    end else begin
      o_class_valid <= post_fire & o_last;
      if (post_fire & o_last) o_class <= fin_i;
      if (post_fire && (o_idx == '0 || gt)) begin
        max_v <= o_data;
        max_i <= o_idx;
      end
      if (pre_fire) begin
        state <= SEND;
        vec <= i_res;
        o_post_valid <= 1'b1;
        o_data <= i_res[0];
        o_idx <= '0;
        o_last <= 1'b0;
      end else if (post_fire & o_last) begin
        state <= IDLE;
        o_post_valid <= 1'b0;
        o_last <= 1'b0;
      end else if (post_fire) begin
        o_data <= vec[nxt];
        o_idx <= nxt;
        o_last <= nxt == IDXW'(LANES - 1);
      end
    end
  end
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: randomized scoreboard bench for the result drain and argmax
module tb_acc_drain;
  import acc_pkg::*;
  logic i_clk = 0, i_rst = 1, i_pre_valid = 0, i_post_ready = 0;
  vec_t i_res;
  logic o_pre_ready, o_post_valid, o_last, o_class_valid;
  logic [DW-1:0] o_data;
  logic [IDXW-1:0] o_idx, o_class;
  typedef struct {logic [DW-1:0] d; logic [IDXW-1:0] i; logic l;} beat_t;
  beat_t beat_q[$];
  int cls_q[$];
  int vectors = 0, miscompares = 0;
  logic rand_rdy = 0, rdy_val = 1, stalled = 0;
  beat_t held;

  acc_drain dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_res(i_res), .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .o_data(o_data), .o_idx(o_idx), .o_last(o_last),
    .o_class_valid(o_class_valid), .o_class(o_class)
  );

  always #5 i_clk = ~i_clk;

  function automatic int argmax(vec_t v);
    int b = 0;
    for (int k = 1; k < LANES; k++) if (v[k] > v[b]) b = k;
    return b;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge i_clk) begin
    #2;
    i_post_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      beat_q.delete();
      cls_q.delete();
      stalled = 0;
    end else begin
      if (o_class_valid) begin
        if (cls_q.size() == 0) chk("class_pulse_unexpected", 1, 0);
        else chk("class", 64'(o_class), 64'(cls_q.pop_front()));
      end
      if (beat_q.size() != 0) chk("beat_valid", 64'(o_post_valid), 1);
      if (stalled) begin
        chk("hold_data", 64'(o_data), 64'(held.d));
        chk("hold_idx", 64'(o_idx), 64'(held.i));
        chk("hold_last", 64'(o_last), 64'(held.l));
      end
      stalled = 0;
      if (o_post_valid && i_post_ready) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          beat_t e;
          e = beat_q.pop_front();
          chk("data", 64'(o_data), 64'(e.d));
          chk("idx", 64'(o_idx), 64'(e.i));
          chk("last", 64'(o_last), 64'(e.l));
        end
      end else if (o_post_valid) begin
        chk("pre_ready_in_stall", 64'(o_pre_ready), 0);
        held = '{o_data, o_idx, o_last};
        stalled = 1;
      end
      if (i_pre_valid && o_pre_ready) begin
        for (int k = 0; k < LANES; k++) beat_q.push_back('{i_res[k], IDXW'(k), k == LANES - 1});
        cls_q.push_back(argmax(i_res));
      end
    end
  end

  function automatic lane_t rand_lane();
    case ($urandom_range(0, 3))
      0: return lane_t'($urandom);
      1: return lane_t'(int'($urandom_range(0, 6)) - 3);
      2: return 32'h7FFFFFFF;
      default: return 32'h80000000;
    endcase
  endfunction

  task automatic send(input vec_t v);
    int t = 0;
    i_res = v;
    i_pre_valid = 1;
    @(negedge i_clk);
    while (!o_pre_ready && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_pre_ready) chk("pre_ready_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    i_pre_valid = 0;
    for (int k = 0; k < LANES; k++) i_res[k] = lane_t'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge i_clk);
    while ((beat_q.size() != 0 || cls_q.size() != 0 || o_post_valid || o_class_valid) && t < 500) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 0, 1);
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_beat(input int n);
    int t = 0;
    @(negedge i_clk);
    while (!(o_post_valid && o_idx == IDXW'(n)) && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 200) chk("beat_wait_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_post_valid"}, 64'(o_post_valid), 0);
    chk({tag, "_data"}, 64'(o_data), 0);
    chk({tag, "_idx"}, 64'(o_idx), 0);
    chk({tag, "_last"}, 64'(o_last), 0);
    chk({tag, "_class_valid"}, 64'(o_class_valid), 0);
    chk({tag, "_class"}, 64'(o_class), 0);
    chk({tag, "_pre_ready"}, 64'(o_pre_ready), 1);
  endtask

  initial begin
    vec_t v;
    for (int k = 0; k < LANES; k++) i_res[k] = '0;
    #1;
    check_reset_outputs("rst0");
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 0;
    rdy_val = 1;
    for (int k = 0; k < LANES; k++) v[k] = k;
    send(v);
    wait_idle();
    chk("class_ascending", 64'(o_class), 9);
    for (int k = 0; k < LANES; k++) v[k] = -100;
    v[3] = -5;
    send(v);
    wait_idle();
    chk("class_signed", 64'(o_class), 3);
    for (int k = 0; k < LANES; k++) v[k] = lane_t'(int'($urandom_range(0, 1000)) - 500);
    v[2] = 32'h7FFFFFFF;
    v[7] = 32'h7FFFFFFF;
    send(v);
    wait_idle();
    chk("class_tie", 64'(o_class), 2);
    for (int k = 0; k < LANES; k++) v[k] = rand_lane();
    send(v);
    wait_beat(3);
    @(posedge i_clk);
    #1;
    rdy_val = 0;
    repeat (3) @(posedge i_clk);
    #1;
    rdy_val = 1;
    wait_idle();
    for (int k = 0; k < LANES; k++) v[k] = rand_lane();
    send(v);
    for (int k = 0; k < LANES; k++) v[k] = rand_lane();
    send(v);
    wait_idle();
    for (int k = 0; k < LANES; k++) v[k] = 100 - k;
    send(v);
    wait_beat(5);
    @(posedge i_clk);
    #1;
    i_rst = 1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 0;
    for (int k = 0; k < LANES; k++) v[k] = k * 3 - 7;
    send(v);
    wait_idle();
    chk("class_after_reset", 64'(o_class), 9);
    rand_rdy = 1;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < LANES; k++) v[k] = rand_lane();
      send(v);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
